// File: rtl/udp_pkg.sv
// UDP header insertion: shared state encoding, header constant,
// latched header fields and checksum substitution helper.
package udp_pkg;

  localparam int UDP_HDR_BYTES = 8;

  typedef enum logic [1:0] {
    IDLE,
    HDR0,
    HDR1,
    PAYLOAD
  } state_t;

  typedef struct packed {
    logic [31:0] ip_dest;
    logic [31:0] ip_src;
    logic [15:0] port_dest;
    logic [15:0] port_src;
    logic [15:0] len;
    logic [15:0] csum;
  } hdr_t;

  // A zero checksum means "not computed" on the wire, so the
  // all-ones form of zero is sent instead.
  function automatic logic [15:0] csum_fix(
    input logic [15:0] c
  );
    return (c == 16'h0000) ? 16'hFFFF : c;
  endfunction

endpackage

// File: rtl/udp_header_insert.sv
// Prepends an 8-byte UDP header (two 32-bit beats) to a payload stream.
// Ports: clk/reset_n; s_* header fields + AXI-S payload in; m_* header+payload out.
module udp_header_insert #(
  parameter int UDP_HDR_BYTES = udp_pkg::UDP_HDR_BYTES
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] s_ip_dest,
  input  logic [31:0] s_ip_src,
  input  logic [15:0] s_port_dest,
  input  logic [15:0] s_port_src,
  input  logic [15:0] s_len,
  input  logic [15:0] s_csum,
  input  logic [31:0] s_tdata,
  input  logic [3:0]  s_tkeep,
  input  logic        s_tlast,
  input  logic        s_tvalid,
  output logic        s_tready,
  output logic [31:0] m_ip_dest,
  output logic [31:0] m_ip_src,
  output logic [31:0] m_tdata,
  output logic [3:0]  m_tkeep,
  output logic        m_tlast,
  output logic        m_tvalid,
  input  logic        m_tready
);

  import udp_pkg::*;

  state_t state;
  state_t state_nxt;
  hdr_t   hdr_q;

  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_last;
  logic        out_valid;

  logic hdr_latch;
  logic s_fire;

  assign s_fire = s_tvalid && s_tready;

  // IDLE may only latch a new header once the previous packet's
  // last beat has left (or is leaving) the output register, so
  // m_ip_* never changes under a pending beat.
  // In HDR1 the register is empty, so the first payload beat is
  // taken in the same cycle the second header word transfers.
  always_comb begin
    state_nxt = state;
    s_tready  = 1'b0;
    hdr_latch = 1'b0;
    unique case (state)
      IDLE: begin
        if (s_tvalid && (!out_valid || m_tready)) begin
          hdr_latch = 1'b1;
          state_nxt = HDR0;
        end
      end
      HDR0: begin
        if (m_tready) state_nxt = HDR1;
      end
      HDR1: begin
        s_tready = m_tready;
        if (m_tready) begin
          if (s_tvalid && s_tlast) state_nxt = IDLE;
          else                     state_nxt = PAYLOAD;
        end
      end
      PAYLOAD: begin
        s_tready = !out_valid || m_tready;
        if (s_tvalid && s_tready && s_tlast) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hdr_q <= '0;
    end else if (hdr_latch) begin
      hdr_q.ip_dest   <= s_ip_dest;
      hdr_q.ip_src    <= s_ip_src;
      hdr_q.port_dest <= s_port_dest;
      hdr_q.port_src  <= s_port_src;
      hdr_q.len       <= s_len;
      hdr_q.csum      <= s_csum;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else if (s_fire) begin
      out_data  <= s_tdata;
      out_keep  <= s_tkeep;
      out_last  <= s_tlast;
      out_valid <= 1'b1;
    end else if (m_tready) begin
      out_valid <= 1'b0;
    end
  end

  logic [15:0] udp_len;
  assign udp_len = hdr_q.len + 16'(UDP_HDR_BYTES);

  always_comb begin
    m_tvalid = out_valid;
    m_tdata  = out_data;
    m_tkeep  = out_keep;
    m_tlast  = out_last;
    unique case (1'b1)
      (state == HDR0): begin
        m_tvalid = 1'b1;
        m_tdata  = {hdr_q.port_src, hdr_q.port_dest};
        m_tkeep  = 4'hF;
        m_tlast  = 1'b0;
      end
      (state == HDR1): begin
        m_tvalid = 1'b1;
        m_tdata  = {udp_len, csum_fix(hdr_q.csum)};
        m_tkeep  = 4'hF;
        m_tlast  = 1'b0;
      end
      default: ;
    endcase
  end

  assign m_ip_dest = hdr_q.ip_dest;
  assign m_ip_src  = hdr_q.ip_src;

endmodule
